// File: rtl/uart_cmd_parser.sv
// UART rx command-frame parser: pops bytes from an rx FIFO, hunts the EB 90 sync word and decodes
// CMD/LEN/payload/CHK frames into a one-cycle command strobe or a one-cycle error strobe.
module uart_cmd_parser #(
    parameter int unsigned MAX_LEN = 4,
    parameter int unsigned TIMEOUT = 110592
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ena_i,
    input  logic                 rx_fifo_empty_i,
    output logic                 rx_fifo_ren_o,
    input  logic [7:0]           rx_fifo_rdata_i,
    output logic                 cmd_valid_o,
    output logic [7:0]           cmd_id_o,
    output logic [7:0]           cmd_len_o,
    output logic [8*MAX_LEN-1:0] cmd_data_o,
    output logic                 frm_err_o,
    output logic [1:0]           err_code_o,
    output logic [15:0]          frm_cnt_o,
    output logic [15:0]          err_cnt_o
);
    localparam int unsigned   TW        = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TMO_LAST  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [7:0]    SYNC1     = 8'hEB;
    localparam logic [7:0]    SYNC2     = 8'h90;
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT1 = 3'd0,
        S_HUNT2 = 3'd1,
        S_CMD   = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_CHK   = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t               state_q, state_d;
    logic                 rd_pend_q;
    logic [TW-1:0]        timer_q, timer_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           chk_q, chk_d;
    logic [4:0]           idx_q, idx_d;
    logic [7:0]           buf_q [MAX_LEN];
    logic [7:0]           buf_d [MAX_LEN];
    logic                 good_s, err_s;
    logic [1:0]           code_s;
    logic                 byte_vld_s;
    logic [7:0]           byte_s;
    logic [8*MAX_LEN-1:0] data_s;

    // A byte is valid the cycle after its read strobe; never two reads in flight.
    assign byte_vld_s    = rd_pend_q;
    assign byte_s        = rx_fifo_rdata_i;
    assign rx_fifo_ren_o = ena_i & ~rd_pend_q & ~rx_fifo_empty_i;

    // Frame parser next-state, checksum accumulation, payload capture and timeout.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        good_s  = 1'b0;
        err_s   = 1'b0;
        code_s  = 2'd0;
        if (!ena_i) begin
            state_d = S_HUNT1;
            timer_d = '0;
        end else if (byte_vld_s) begin
            timer_d = '0;
            case (state_q)
                S_HUNT1: state_d = (byte_s == SYNC1) ? S_HUNT2 : S_HUNT1;
                S_HUNT2: begin
                    if (byte_s == SYNC2) begin
                        state_d = S_CMD;
                    end else if (byte_s == SYNC1) begin
                        state_d = S_HUNT2;
                    end else begin
                        state_d = S_HUNT1;
                    end
                end
                S_CMD: begin
                    cmd_d   = byte_s;
                    chk_d   = byte_s;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    if (byte_s > MAX_LEN_B) begin
                        err_s   = 1'b1;
                        code_s  = 2'd1;
                        state_d = S_HUNT1;
                    end else begin
                        len_d = byte_s;
                        chk_d = chk_q + byte_s;
                        idx_d = 5'd0;
                        if (byte_s != 8'd0) begin
                            state_d = S_DATA;
                            for (int i = 0; i < int'(MAX_LEN); i++) begin
                                buf_d[i] = 8'h00;
                            end
                        end else begin
                            state_d = S_CHK;
                        end
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        buf_d[i] = ({3'd0, idx_q} == 8'(i)) ? byte_s : buf_q[i];
                    end
                    chk_d   = chk_q + byte_s;
                    idx_d   = idx_q + 5'd1;
                    state_d = ({3'd0, idx_q} == (len_q - 8'd1)) ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    if (byte_s == chk_q) begin
                        good_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                        code_s = 2'd2;
                    end
                    state_d = S_HUNT1;
                end
                default: state_d = S_HUNT1;
            endcase
        end else if (state_q inside {S_CMD, S_LEN, S_DATA, S_CHK}) begin
            if ((TIMEOUT != 32'd0) && (timer_q == TMO_LAST)) begin
                err_s   = 1'b1;
                code_s  = 2'd3;
                state_d = S_HUNT1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // Presented payload: bytes at or beyond LEN read as zero even if the buffer holds older data.
    always_comb begin
        data_s = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            data_s[8*i +: 8] = (8'(i) < len_q) ? buf_q[i] : 8'h00;
        end
    end

    // Parser state, read handshake and payload buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_HUNT1;
            rd_pend_q <= 1'b0;
            timer_q   <= '0;
            cmd_q     <= 8'h00;
            len_q     <= 8'h00;
            chk_q     <= 8'h00;
            idx_q     <= 5'd0;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rx_fifo_ren_o;
            timer_q   <= timer_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
        end
    end

    // Registered command/error outputs and saturating frame/error counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_valid_o <= 1'b0;
            cmd_id_o    <= 8'h00;
            cmd_len_o   <= 8'h00;
            cmd_data_o  <= '0;
            frm_err_o   <= 1'b0;
            err_code_o  <= 2'd0;
            frm_cnt_o   <= 16'd0;
            err_cnt_o   <= 16'd0;
        end else begin
            cmd_valid_o <= good_s;
            frm_err_o   <= err_s;
            if (good_s) begin
                cmd_id_o   <= cmd_q;
                cmd_len_o  <= len_q;
                cmd_data_o <= data_s;
                frm_cnt_o  <= sat_inc16(frm_cnt_o);
            end
            if (err_s) begin
                err_code_o <= code_s;
                err_cnt_o  <= sat_inc16(err_cnt_o);
            end
        end
    end
endmodule
